// File: rtl/pe_schedule_ctrl.sv
// Phase sequencer for the two-PE CORDIC array: walks an NxN matrix in 2x2 groups,
// issuing PE operands per pass and matching write-back strobes PE_LAT cycles later.
module pe_schedule_ctrl #(
    parameter int unsigned N      = 4,
    parameter int unsigned PE_LAT = 8,
    parameter int unsigned NPASS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           pe0_valid_o,
    output logic [1:0]           pe1_valid_o,
    output logic [1:0]           pe0_scheme_o,
    output logic [1:0]           pe1_scheme_o,
    output logic [$clog2(N)-1:0] rd_row_o,
    output logic [$clog2(N)-1:0] rd_col_o,
    output logic                 fb_sel_o,
    output logic                 swap_o,
    output logic                 wb_en_o,
    output logic [$clog2(N)-1:0] wb_row_o,
    output logic [$clog2(N)-1:0] wb_col_o,
    output logic                 wb_swap_o
);
    localparam int unsigned HALF = N / 2;
    localparam int unsigned G    = HALF * HALF;
    localparam int unsigned CW   = $clog2(NPASS * PE_LAT + G + 1);
    localparam int unsigned RW   = $clog2(N);

    localparam logic [CW-1:0] LAT_C   = CW'(PE_LAT);
    localparam logic [CW-1:0] NPASS_C = CW'(NPASS);
    localparam logic [CW-1:0] G_C     = CW'(G);
    localparam logic [CW-1:0] HALF_C  = CW'(HALF);
    localparam logic [CW-1:0] LAST_C  = CW'(NPASS * PE_LAT + G - 1);

    if (N < 2 || (N % 2) != 0 || NPASS < 1 || PE_LAT < G) begin : g_param_err
        $error("pe_schedule_ctrl: need even N>=2, NPASS>=1, PE_LAT>=(N/2)*(N/2)");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SCH_C2R   = 2'd0,
        SCH_CROT  = 2'd1,
        SCH_RNULL = 2'd2,
        SCH_RROT  = 2'd3
    } scheme_e;

    state_e        state_q, state_d;
    logic [CW-1:0] p_q, p_d;

    logic [CW-1:0] iss_pass, iss_grp, iss_rp, iss_cp;
    logic [CW-1:0] wb_pos, wb_pass, wb_grp, wb_rp, wb_cp;
    logic          iss_hit, wb_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                p_d = '0;
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (p_q == LAST_C) begin
                    state_d = S_DONE;
                    p_d     = '0;
                end else begin
                    p_d = p_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                p_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                p_d     = '0;
            end
        endcase
    end

    // Phase P splits into pass/group; write-back replays the slot PE_LAT cycles earlier.
    always_comb begin
        iss_pass = p_q / LAT_C;
        iss_grp  = p_q % LAT_C;
        iss_rp   = iss_grp / HALF_C;
        iss_cp   = iss_grp % HALF_C;
        iss_hit  = (iss_pass < NPASS_C) && (iss_grp < G_C);
        wb_pos   = p_q - LAT_C;
        wb_pass  = wb_pos / LAT_C;
        wb_grp   = wb_pos % LAT_C;
        wb_rp    = wb_grp / HALF_C;
        wb_cp    = wb_grp % HALF_C;
        wb_hit   = (p_q >= LAT_C) && (wb_pass < NPASS_C) && (wb_grp < G_C);
    end

    always_comb begin
        busy_o       = (state_q == S_RUN);
        done_o       = (state_q == S_DONE);
        pe0_valid_o  = '0;
        pe1_valid_o  = '0;
        pe0_scheme_o = '0;
        pe1_scheme_o = '0;
        rd_row_o     = '0;
        rd_col_o     = '0;
        fb_sel_o     = 1'b0;
        swap_o       = 1'b0;
        wb_en_o      = 1'b0;
        wb_row_o     = '0;
        wb_col_o     = '0;
        wb_swap_o    = 1'b0;
        if (state_q == S_RUN && iss_hit) begin
            pe0_valid_o = '1;
            pe1_valid_o = '1;
            rd_row_o    = RW'({iss_rp, 1'b0});
            rd_col_o    = RW'({iss_cp, 1'b0});
            if (iss_pass == '0) begin
                pe0_scheme_o = (iss_cp == '0) ? SCH_C2R : SCH_CROT;
                pe1_scheme_o = SCH_CROT;
            end else begin
                fb_sel_o     = 1'b1;
                swap_o       = iss_rp[0];
                pe0_scheme_o = (iss_cp == '0) ? SCH_RNULL : SCH_RROT;
                pe1_scheme_o = SCH_RROT;
            end
        end
        if (state_q == S_RUN && wb_hit) begin
            wb_en_o   = 1'b1;
            wb_row_o  = RW'({wb_rp, 1'b0});
            wb_col_o  = RW'({wb_cp, 1'b0});
            wb_swap_o = (wb_pass != '0) && wb_rp[0];
        end
    end

endmodule

// File: tb/tb_pe_schedule_ctrl.sv
// Directed bench for pe_schedule_ctrl: default config (N=4, PE_LAT=8, NPASS=2)
// plus a minimal config (N=2, PE_LAT=1, NPASS=3).
module tb_pe_schedule_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic       busy, done, fb_sel, swap, wb_en, wb_swap;
    logic [1:0] pe0_valid, pe1_valid, pe0_scheme, pe1_scheme;
    logic [1:0] rd_row, rd_col, wb_row, wb_col;

    logic       rst2, start2;
    logic       busy2, done2, fb_sel2, swap2, wb_en2, wb_swap2;
    logic [1:0] pe0_valid2, pe1_valid2, pe0_scheme2, pe1_scheme2;
    logic [0:0] rd_row2, rd_col2, wb_row2, wb_col2;

    int checks   = 0;
    int failures = 0;

    pe_schedule_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .pe0_valid_o(pe0_valid), .pe1_valid_o(pe1_valid),
        .pe0_scheme_o(pe0_scheme), .pe1_scheme_o(pe1_scheme),
        .rd_row_o(rd_row), .rd_col_o(rd_col), .fb_sel_o(fb_sel), .swap_o(swap),
        .wb_en_o(wb_en), .wb_row_o(wb_row), .wb_col_o(wb_col), .wb_swap_o(wb_swap)
    );

    pe_schedule_ctrl #(.N(2), .PE_LAT(1), .NPASS(3)) dut2 (
        .clk(clk), .rst(rst2), .start_i(start2), .busy_o(busy2), .done_o(done2),
        .pe0_valid_o(pe0_valid2), .pe1_valid_o(pe1_valid2),
        .pe0_scheme_o(pe0_scheme2), .pe1_scheme_o(pe1_scheme2),
        .rd_row_o(rd_row2), .rd_col_o(rd_col2), .fb_sel_o(fb_sel2), .swap_o(swap2),
        .wb_en_o(wb_en2), .wb_row_o(wb_row2), .wb_col_o(wb_col2), .wb_swap_o(wb_swap2)
    );

    logic [21:0] obs;
    logic [17:0] obs2;
    assign obs  = {pe0_valid, pe1_valid, pe0_scheme, pe1_scheme, rd_row, rd_col,
                   fb_sel, swap, wb_en, wb_row, wb_col, wb_swap, busy, done};
    assign obs2 = {pe0_valid2, pe1_valid2, pe0_scheme2, pe1_scheme2, rd_row2, rd_col2,
                   fb_sel2, swap2, wb_en2, wb_row2, wb_col2, wb_swap2, busy2, done2};

    // Hand-derived per-group tables for N=4: groups ordered row-pair major.
    localparam logic [1:0] ROW_T [4] = '{2'd0, 2'd0, 2'd2, 2'd2};
    localparam logic [1:0] COL_T [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    localparam logic       SW_T  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [1:0] S0P0_T[4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    localparam logic [1:0] S0P1_T[4] = '{2'd2, 2'd3, 2'd2, 2'd3};

    function automatic logic [21:0] exp_vec(input int p);
        logic [1:0] v, s0, s1, row, col, wrow, wcol;
        logic       fb, sw, we, ws;
        int         g;
        v = '0; s0 = '0; s1 = '0; row = '0; col = '0; wrow = '0; wcol = '0;
        fb = 1'b0; sw = 1'b0; we = 1'b0; ws = 1'b0;
        if (p >= 0 && p <= 3) begin
            g = p; v = 2'b11; row = ROW_T[g]; col = COL_T[g];
            s0 = S0P0_T[g]; s1 = 2'd1;
        end else if (p >= 8 && p <= 11) begin
            g = p - 8; v = 2'b11; row = ROW_T[g]; col = COL_T[g];
            s0 = S0P1_T[g]; s1 = 2'd3; fb = 1'b1; sw = SW_T[g];
        end
        if (p >= 8 && p <= 11) begin
            g = p - 8; we = 1'b1; wrow = ROW_T[g]; wcol = COL_T[g];
        end else if (p >= 16 && p <= 19) begin
            g = p - 16; we = 1'b1; wrow = ROW_T[g]; wcol = COL_T[g]; ws = SW_T[g];
        end
        return {v, v, s0, s1, row, col, fb, sw, we, wrow, wcol, ws,
                (p >= 0 && p <= 19), (p == 20)};
    endfunction

    function automatic logic [17:0] exp2(input int p);
        case (p)
            0:       return {2'b11, 2'b11, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            1, 2:    return {2'b11, 2'b11, 2'd2, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            3:       return {2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            4:       return 18'd1;
            default: return 18'd0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
        tick; tick;
        rst = 1'b0; rst2 = 1'b0;
        checks++;
        if (obs !== 22'd0) begin
            failures++; $display("FAIL reset_main got=%h exp=%h", obs, 22'd0);
        end
        checks++;
        if (obs2 !== 18'd0) begin
            failures++; $display("FAIL reset_small got=%h exp=%h", obs2, 18'd0);
        end
        tick;
        checks++;
        if (obs !== 22'd0) begin
            failures++; $display("FAIL idle_no_start got=%h exp=%h", obs, 22'd0);
        end
    endtask

    task automatic test_schedule;
        start = 1'b1; tick; start = 1'b0;
        for (int p = 0; p <= 20; p++) begin
            checks++;
            if (obs !== exp_vec(p)) begin
                failures++; $display("FAIL sched P=%0d got=%h exp=%h", p, obs, exp_vec(p));
            end
            if (p == 10) begin
                checks++;
                if ({pe0_scheme, pe1_scheme, rd_row, rd_col, fb_sel, swap} !==
                    {2'd2, 2'd3, 2'd2, 2'd0, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL p10_issue got=%h exp=%h",
                             {pe0_scheme, pe1_scheme, rd_row, rd_col, fb_sel, swap},
                             {2'd2, 2'd3, 2'd2, 2'd0, 1'b1, 1'b1});
                end
            end
            if (p == 18) begin
                checks++;
                if ({wb_en, wb_row, wb_col, wb_swap} !== {1'b1, 2'd2, 2'd0, 1'b1}) begin
                    failures++;
                    $display("FAIL p18_wb got=%h exp=%h",
                             {wb_en, wb_row, wb_col, wb_swap}, {1'b1, 2'd2, 2'd0, 1'b1});
                end
            end
            tick;
        end
        checks++;
        if (obs !== 22'd0) begin
            failures++; $display("FAIL after_done got=%h exp=%h", obs, 22'd0);
        end
    endtask

    task automatic test_back_to_back;
        start = 1'b1; tick;
        for (int p = 0; p <= 20; p++) begin
            checks++;
            if (obs !== exp_vec(p)) begin
                failures++; $display("FAIL b2b_first P=%0d got=%h exp=%h", p, obs, exp_vec(p));
            end
            tick;
        end
        checks++;
        if (obs !== 22'd0) begin
            failures++; $display("FAIL b2b_idle_gap got=%h exp=%h", obs, 22'd0);
        end
        tick;
        start = 1'b0;
        for (int p = 0; p <= 20; p++) begin
            checks++;
            if (obs !== exp_vec(p)) begin
                failures++; $display("FAIL b2b_second P=%0d got=%h exp=%h", p, obs, exp_vec(p));
            end
            tick;
        end
        checks++;
        if (obs !== 22'd0) begin
            failures++; $display("FAIL b2b_end got=%h exp=%h", obs, 22'd0);
        end
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1; tick; start = 1'b0;
        for (int p = 0; p <= 9; p++) begin
            checks++;
            if (obs !== exp_vec(p)) begin
                failures++; $display("FAIL pre_rst P=%0d got=%h exp=%h", p, obs, exp_vec(p));
            end
            if (p == 9) rst = 1'b1;
            tick;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== 22'd0) begin
                failures++; $display("FAIL post_rst cyc=%0d got=%h exp=%h", i, obs, 22'd0);
            end
            tick;
        end
        start = 1'b1; tick; start = 1'b0;
        for (int p = 0; p <= 20; p++) begin
            checks++;
            if (obs !== exp_vec(p)) begin
                failures++; $display("FAIL restart P=%0d got=%h exp=%h", p, obs, exp_vec(p));
            end
            tick;
        end
    endtask

    task automatic test_small_config;
        start2 = 1'b1; tick; start2 = 1'b0;
        for (int p = 0; p <= 4; p++) begin
            checks++;
            if (obs2 !== exp2(p)) begin
                failures++; $display("FAIL small P=%0d got=%h exp=%h", p, obs2, exp2(p));
            end
            tick;
        end
        checks++;
        if (obs2 !== 18'd0) begin
            failures++; $display("FAIL small_end got=%h exp=%h", obs2, 18'd0);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [1:0] row;
        logic [1:0] col;
        logic       sw;
    } issue_t;

    task automatic test_scoreboard;
        issue_t q[$];
        issue_t e;
        int     matched = 0;
        bit     seen_done = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
            if (wb_en === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL sb_unexpected_wb cyc=%0d got=wb exp=none", cyc);
                end else begin
                    e = q.pop_front();
                    if ({wb_row, wb_col, wb_swap} !== {e.row, e.col, e.sw} || cyc != e.cyc + 8) begin
                        failures++;
                        $display("FAIL sb_match cyc=%0d got=%h@%0d exp=%h@%0d", cyc,
                                 {wb_row, wb_col, wb_swap}, cyc, {e.row, e.col, e.sw}, e.cyc + 8);
                    end else begin
                        matched++;
                    end
                end
            end
            if (pe0_valid === 2'b11) begin
                q.push_back('{cyc, rd_row, rd_col, swap});
                checks++;
                if (pe1_valid !== 2'b11) begin
                    failures++; $display("FAIL sb_pe1_valid cyc=%0d got=%b exp=11", cyc, pe1_valid);
                end
            end
            if (done === 1'b1) seen_done = 1'b1;
            tick;
        end
        checks++;
        if (!seen_done) begin
            failures++; $display("FAIL sb_timeout got=no_done exp=done_within_40");
        end
        checks++;
        if (matched != 8) begin
            failures++; $display("FAIL sb_count got=%0d exp=8", matched);
        end
        checks++;
        if (q.size() != 0) begin
            failures++; $display("FAIL sb_leftover got=%0d exp=0", q.size());
        end
    endtask

    initial begin
        test_reset;
        test_schedule;
        test_back_to_back;
        test_reset_mid_run;
        test_small_config;
        test_scoreboard;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
